// File: rtl/floppy_pkg.sv
// Shared defaults and state encoding for the GCR read-data separator.
// Imported by the separator top level.
package floppy_pkg;

  localparam int unsigned CELL_CLKS_DEF = 64;
  localparam int unsigned MAX_ZEROS_DEF = 2;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } sep_state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for rd_pulse.
// Edges are suppressed until a genuine low level has been sampled.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic seen_q, seen_d;
  logic armed_q, armed_d;
  logic edge_q, edge_d;

  // Shift the sample chain; arm only after a real post-reset low sample.
  always_comb begin
    s1_d    = pulse_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    seen_d  = 1'b1;
    armed_d = armed_q | (seen_q & ~s1_q);
    edge_d  = s2_q & ~s3_q & armed_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      seen_q  <= 1'b0;
      armed_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      seen_q  <= seen_d;
      armed_q <= armed_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/gcr_data_separator.sv
// Recovers bit cells and MSB-first bytes from floppy read-data pulses.
// HUNT waits for a pulse; TRACK keeps a cell window centred on pulses.
module gcr_data_separator
  import floppy_pkg::*;
#(
  parameter int unsigned CELL_CLKS = CELL_CLKS_DEF,
  parameter int unsigned MAX_ZEROS = MAX_ZEROS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rd_pulse,
  output logic       bit_strobe,
  output logic       bit_val,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       sync_lost
);

  localparam int unsigned CW = $clog2(CELL_CLKS);
  localparam int unsigned ZW = $clog2(MAX_ZEROS + 2);
  localparam logic [CW-1:0] HALF = CW'(CELL_CLKS / 2);
  localparam logic [CW-1:0] LAST = CW'(CELL_CLKS - 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(MAX_ZEROS);

  logic edge_pulse;

  sep_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [ZW-1:0] zrun_q, zrun_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    byte_q, byte_d;
  logic          strobe_q, strobe_d;
  logic          val_q, val_d;
  logic          bvalid_q, bvalid_d;
  logic          lost_q, lost_d;

  logic          bit_now;
  logic [7:0]    shifted;

  pulse_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (rd_pulse),
    .edge_pulse(edge_pulse)
  );

  // Next-state: window counter, bit decision, zero-run and byte assembly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    zrun_d   = zrun_q;
    sr_d     = sr_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    val_d    = 1'b0;
    bvalid_d = 1'b0;
    lost_d   = 1'b0;
    bit_now  = 1'b0;
    shifted  = 8'h00;
    if (!enable) begin
      state_d = HUNT;
      cnt_d   = '0;
      pend_d  = 1'b0;
      zrun_d  = '0;
      sr_d    = 8'h00;
    end else begin
      unique case (state_q)
        HUNT: begin
          cnt_d  = '0;
          pend_d = 1'b0;
          if (edge_pulse) begin
            state_d = TRACK;
            cnt_d   = HALF;
            pend_d  = 1'b1;
          end
        end
        TRACK: begin
          if (cnt_q == LAST) begin
            bit_now  = pend_q | edge_pulse;
            shifted  = {sr_q[6:0], bit_now};
            strobe_d = 1'b1;
            val_d    = bit_now;
            pend_d   = 1'b0;
            cnt_d    = edge_pulse ? HALF : '0;
            if (!bit_now && zrun_q == ZMAX) begin
              lost_d  = 1'b1;
              state_d = HUNT;
              sr_d    = 8'h00;
              zrun_d  = '0;
              cnt_d   = '0;
            end else begin
              zrun_d = bit_now ? '0 : zrun_q + ZW'(1);
              if (shifted[7]) begin
                byte_d   = shifted;
                bvalid_d = 1'b1;
                sr_d     = 8'h00;
              end else if (bit_now || sr_q != 8'h00) begin
                sr_d = shifted;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (edge_pulse) begin
              cnt_d  = HALF;
              pend_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      zrun_q   <= '0;
      sr_q     <= 8'h00;
      byte_q   <= 8'h00;
      strobe_q <= 1'b0;
      val_q    <= 1'b0;
      bvalid_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      zrun_q   <= zrun_d;
      sr_q     <= sr_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
      val_q    <= val_d;
      bvalid_q <= bvalid_d;
      lost_q   <= lost_d;
    end
  end

  assign bit_strobe = strobe_q;
  assign bit_val    = val_q;
  assign byte_valid = bvalid_q;
  assign byte_data  = byte_q;
  assign sync_lost  = lost_q;

endmodule
